// File: rtl/clk_mon_pkg.sv
// Shared definitions for the divided-clock ratio monitors: generation
// encodings, monitor state encoding and default expected periods.
package clk_mon_pkg;

  // Width of the period counter and of the reported period.
  localparam int PERIOD_W = 8;

  // gen_speed encodings. The fourth code falls back to the generation 0 period.
  localparam logic [1:0] GEN_SPEED_0 = 2'd0;
  localparam logic [1:0] GEN_SPEED_1 = 2'd1;
  localparam logic [1:0] GEN_SPEED_2 = 2'd2;

  // Default expected mon_clk periods in local_clk cycles.
  localparam int DEF_EXP_P0 = 16;
  localparam int DEF_EXP_P1 = 33;
  localparam int DEF_EXP_P2 = 68;

  // Monitor states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } mon_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, followed by a third flop
// that turns a synchronized low-to-high transition into a one-cycle pulse.
module sync_edge_det (
  input  logic local_clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Synchronizer chain plus the delayed copy used for edge detection.
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures the rising-edge-to-rising-edge period of a divided clock (sampled
// as data) in local_clk cycles and tracks lock, fault and timeout status
// against the expected period for the selected generation.
module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXP_P0    = DEF_EXP_P0,
  parameter int EXP_P1    = DEF_EXP_P1,
  parameter int EXP_P2    = DEF_EXP_P2,
  parameter int TOL       = 1,
  parameter int LOCK_CNT  = 4,
  parameter int FAULT_CNT = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                local_clk,
  input  logic                rst,
  input  logic [1:0]          gen_speed,
  input  logic                mon_clk,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                fault,
  output logic                timeout
);

  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] LOCK_V    = PERIOD_W'(LOCK_CNT);
  localparam logic [PERIOD_W-1:0] FAULT_V   = PERIOD_W'(FAULT_CNT);
  localparam logic [PERIOD_W:0]   TOL_V     = (PERIOD_W+1)'(TOL);

  // Expected period for a generation, widened so it compares against a
  // measurement that can reach 2**PERIOD_W.
  function automatic logic [PERIOD_W:0] exp_period(input logic [1:0] gs);
    case (gs)
      GEN_SPEED_1: return (PERIOD_W+1)'(EXP_P1);
      GEN_SPEED_2: return (PERIOD_W+1)'(EXP_P2);
      default:     return (PERIOD_W+1)'(EXP_P0);
    endcase
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (v == '1) ? v : v + PERIOD_W'(1);
  endfunction

  // Clamp a widened measurement into the reported period width.
  function automatic logic [PERIOD_W-1:0] sat_period(input logic [PERIOD_W:0] v);
    return v[PERIOD_W] ? '1 : v[PERIOD_W-1:0];
  endfunction

  // Absolute difference without relying on signed wrap-around.
  function automatic logic [PERIOD_W:0] abs_diff(input logic [PERIOD_W:0] a,
                                                 input logic [PERIOD_W:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  mon_state_e          state, state_n;
  logic [PERIOD_W-1:0] cnt, cnt_n;
  logic [PERIOD_W-1:0] good_cnt, good_n;
  logic [PERIOD_W-1:0] bad_cnt, bad_n;
  logic                armed, armed_n;
  logic [1:0]          gen_q;
  logic [PERIOD_W-1:0] period_n;
  logic                pv_n;
  logic                locked_n;
  logic                fault_n;
  logic                timeout_n;

  logic                rise;
  logic                speed_chg;
  logic [PERIOD_W:0]   meas;
  logic                is_good;

  sync_edge_det u_sync (
    .local_clk (local_clk),
    .rst       (rst),
    .din       (mon_clk),
    .rise      (rise)
  );

  assign speed_chg = (gen_speed != gen_q);
  assign meas      = {1'b0, cnt} + (PERIOD_W+1)'(1);
  assign is_good   = (abs_diff(meas, exp_period(gen_q)) <= TOL_V);

  // Next-state, counter and status decisions for the current cycle.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    good_n    = good_cnt;
    bad_n     = bad_cnt;
    armed_n   = armed;
    period_n  = period;
    pv_n      = 1'b0;
    timeout_n = timeout;

    if (speed_chg) begin
      // A generation change restarts acquisition and discards any edge.
      state_n   = IDLE;
      cnt_n     = '0;
      good_n    = '0;
      bad_n     = '0;
      armed_n   = 1'b0;
      timeout_n = 1'b0;
    end else if (rise) begin
      cnt_n = '0;
      if (!armed) begin
        // First edge after reset, speed change or timeout only starts a measurement.
        armed_n = 1'b1;
        if (state == IDLE) state_n = ACQ;
      end else begin
        period_n = sat_period(meas);
        pv_n     = 1'b1;
        case (state)
          ACQ, FAULT: begin
            if (is_good) begin
              if (good_cnt + PERIOD_W'(1) == LOCK_V) begin
                state_n   = LOCKED;
                good_n    = '0;
                bad_n     = '0;
                timeout_n = 1'b0;
              end else begin
                good_n = good_cnt + PERIOD_W'(1);
              end
            end else begin
              good_n = '0;
            end
          end
          LOCKED: begin
            if (!is_good) begin
              if (bad_cnt + PERIOD_W'(1) == FAULT_V) begin
                state_n   = FAULT;
                good_n    = '0;
                bad_n     = '0;
                timeout_n = 1'b0;
              end else begin
                bad_n = bad_cnt + PERIOD_W'(1);
              end
            end else begin
              bad_n = '0;
            end
          end
          default: ;
        endcase
      end
    end else if (armed && (state != IDLE) && (cnt == TIMEOUT_V)) begin
      // No edge for too long: hold the counter and wait to re-arm.
      state_n   = FAULT;
      timeout_n = 1'b1;
      good_n    = '0;
      bad_n     = '0;
      armed_n   = 1'b0;
    end else begin
      cnt_n = sat_inc(cnt);
    end

    locked_n = (state_n == LOCKED);
    fault_n  = (state_n == FAULT);
  end

  // State register.
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Counters, generation copy and registered status outputs.
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      armed        <= 1'b0;
      gen_q        <= GEN_SPEED_0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      fault        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      cnt          <= cnt_n;
      good_cnt     <= good_n;
      bad_cnt      <= bad_n;
      armed        <= armed_n;
      gen_q        <= gen_speed;
      period       <= period_n;
      period_valid <= pv_n;
      locked       <= locked_n;
      fault        <= fault_n;
      timeout      <= timeout_n;
    end
  end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor: a mon_clk generator pushes every measurable
// period into a scoreboard queue; a monitor pops it on each period_valid.
module tb_clk_ratio_monitor;

  logic       local_clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] gen_speed = 2'd0;
  logic       mon_clk = 1'b0;
  logic [7:0] period;
  logic       period_valid;
  logic       locked;
  logic       fault;
  logic       timeout;

  int checks = 0;
  int failures = 0;
  int sb_q[$];
  int mon_period = 0;
  int skip = 0;
  int cyc = 0;
  int last_rise = 0;
  event rise_ev;

  always #5 local_clk = ~local_clk;

  clk_ratio_monitor dut (
    .local_clk    (local_clk),
    .rst          (rst),
    .gen_speed    (gen_speed),
    .mon_clk      (mon_clk),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .fault        (fault),
    .timeout      (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic flags(input string tag, input int l, input int f, input int t);
    chk({tag, "_locked"}, locked, l);
    chk({tag, "_fault"}, fault, f);
    chk({tag, "_timeout"}, timeout, t);
  endtask

  // Wait for n period_valid pulses, sampled 1 time unit after the clock edge.
  task automatic wait_pv(input int n);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < 2000) begin
      @(posedge local_clk);
      #1;
      budget++;
      if (period_valid) seen++;
    end
    if (seen < n) chk("wait_pv_timeout", seen, n);
  endtask

  // Stop mon_clk, change generation while idle, restart at period p.
  task automatic switch_gen(input logic [1:0] g, input int p);
    mon_period = 0;
    repeat (80) @(posedge local_clk);
    @(negedge local_clk);
    gen_speed = g;
    skip = 1;
    @(negedge local_clk);
    flags("gen_switch", 0, 0, 0);
    mon_period = p;
  endtask

  always @(posedge local_clk) cyc <= cyc + 1;

  // mon_clk generator: rises on a falling local_clk edge, period latched per rise.
  initial begin : mon_gen
    int p;
    forever begin
      @(negedge local_clk);
      if (mon_period == 0) begin
        mon_clk = 1'b0;
      end else begin
        p = mon_period;
        mon_clk = 1'b1;
        if (skip > 0) skip--;
        else sb_q.push_back(cyc - last_rise);
        last_rise = cyc;
        ->rise_ev;
        repeat (p / 2 - 1) @(negedge local_clk);
        @(negedge local_clk);
        mon_clk = 1'b0;
        repeat (p - p / 2 - 1) @(negedge local_clk);
      end
    end
  end

  // Scoreboard monitor.
  initial begin : sb_mon
    forever begin
      @(negedge local_clk);
      if (rst && period_valid) begin
        if (sb_q.size() == 0) chk("pv_unexpected", period_valid, 0);
        else chk("period", period, sb_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Reset values.
    repeat (3) @(posedge local_clk);
    #1;
    chk("rst_period", period, 0);
    chk("rst_pv", period_valid, 0);
    flags("rst", 0, 0, 0);
    @(negedge local_clk);
    rst = 1'b1;
    skip = 1;
    @(negedge local_clk);
    mon_period = 18;

    // Period 18 at gen 0 is out of tolerance: never locks.
    wait_pv(6);
    flags("p18", 0, 0, 0);

    // Period 17 is within tolerance: lock on the 4th good period.
    mon_period = 17;
    wait_pv(1);
    wait_pv(3);
    flags("p17_pre", 0, 0, 0);
    wait_pv(1);
    flags("p17_lock", 1, 0, 0);

    // Gen 1 at 33, then stop mon_clk to provoke a timeout.
    switch_gen(2'd1, 33);
    wait_pv(3);
    flags("g1_pre", 0, 0, 0);
    wait_pv(1);
    flags("g1_lock", 1, 0, 0);
    @(rise_ev);
    mon_period = 0;
    repeat (250) @(posedge local_clk);
    #1;
    flags("to_pre", 1, 0, 0);
    repeat (12) @(posedge local_clk);
    #1;
    flags("to", 0, 1, 1);
    skip = 1;
    mon_period = 33;
    wait_pv(3);
    flags("to_re_pre", 0, 1, 1);
    wait_pv(1);
    flags("to_relock", 1, 0, 0);

    // Gen change coincident with a processed edge.
    @(rise_ev);
    skip = 2;
    @(rise_ev);
    @(negedge local_clk);
    @(negedge local_clk);
    flags("chg_pre", 1, 0, 0);
    gen_speed = 2'd2;
    mon_period = 68;
    @(posedge local_clk);
    #1;
    flags("chg", 0, 0, 0);
    chk("chg_pv", period_valid, 0);
    wait_pv(3);
    flags("g2_pre", 0, 0, 0);
    wait_pv(1);
    flags("g2_lock", 1, 0, 0);

    // Two bad periods then a good one keep lock.
    mon_period = 40;
    wait_pv(1);
    wait_pv(1);
    mon_period = 68;
    flags("bad1", 1, 0, 0);
    wait_pv(1);
    flags("bad2", 1, 0, 0);
    wait_pv(1);
    flags("bad_recover", 1, 0, 0);

    // Three bad periods in a row give a fault.
    mon_period = 40;
    wait_pv(1);
    wait_pv(2);
    flags("f3_pre", 1, 0, 0);
    wait_pv(1);
    flags("f3", 0, 1, 0);

    // Gen 0 at 16 locks on the 4th good period.
    switch_gen(2'd0, 16);
    wait_pv(3);
    flags("g0_pre", 0, 0, 0);
    wait_pv(1);
    flags("g0_lock", 1, 0, 0);

    // Gen 3 uses the gen 0 period; reset mid-acquisition.
    switch_gen(2'd3, 16);
    wait_pv(2);
    flags("g3_acq", 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_period", period, 0);
    chk("mid_rst_pv", period_valid, 0);
    flags("mid_rst", 0, 0, 0);
    mon_period = 0;
    repeat (40) @(posedge local_clk);
    sb_q.delete();
    skip = 1;
    @(negedge local_clk);
    rst = 1'b1;
    @(negedge local_clk);
    mon_period = 16;
    wait_pv(3);
    flags("post_rst_pre", 0, 0, 0);
    wait_pv(1);
    flags("post_rst_lock", 1, 0, 0);

    mon_period = 0;
    repeat (100) @(posedge local_clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
